imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the CPU's instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives word-addressed write requests into the instruction memory's write port. It holds the CPU in reset until a complete frame with a correct checksum has been written.

## Interface
- ADDR_WIDTH, 12, instruction-memory word-address width; capacity 2^ADDR_WIDTH words.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to begin a new load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_WIDTH  word address (byte address >> 2).
- wr_data  out  32  instruction word.
- cpu_reset  out  1  high holds the CPU in reset.
- done  out  1  level; load finished with a good checksum.
- error  out  1  level; load aborted or checksum failed.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N), then 4*N data bytes with the most significant byte first, then one CHK byte.
- CHK must equal the XOR of LEN_HI, LEN_LO and all data bytes.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- States are IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE and ERROR.
- IDLE/DONE/ERROR + start → LEN_HI. On that edge: cpu_reset=1, done=0, error=0, wr_addr=0, checksum accumulator=0.
- start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- LEN_HI: accept a byte → LEN_LO.
- LEN_LO: accept a byte, then:
  - N==0 → CHECK.
  - N > 2^ADDR_WIDTH → ERROR.
  - Otherwise → DATA.
- DATA: shift each accepted byte into a 32-bit assembly register, with the first byte landing in [31:24].
  - On the 4th byte of a word: wr_data is set to the assembled word, wr_en=1 for the next cycle only, and wr_addr holds the current word index.
  - wr_addr increments by 1 after each write strobe.
  - After the N-th word → CHECK.
- CHECK: accept one byte.
  - Equal to the accumulator → DONE: done=1, cpu_reset=0.
  - Not equal → ERROR: error=1, cpu_reset stays 1.
- rx_ready is 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 in IDLE, DONE and ERROR.
- Words already written before an ERROR are not retracted; cpu_reset=1 keeps them from executing.
- No timeout. Gaps in rx_valid stall the loader indefinitely, with no state change.
- Reset mid-load: go to IDLE at once and discard the partial word, count and checksum. Memory contents are not touched.

## Timing
- Reset values:
  - State = IDLE.
  - rx_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_reset=1, done=0, error=0.
- All outputs are registered or decoded from registered state only; no combinational path from rx_* to any output.
- Write latency: wr_en is high during the cycle after the edge that accepted the word's 4th byte.
  - wr_addr and wr_data are stable during that cycle.
  - wr_addr advances at the following edge.
- Throughput: one byte per cycle with rx_valid held high, i.e. one word per 4 cycles. Back-to-back write strobes are 4 cycles apart.
- done/error rise, and cpu_reset falls, in the cycle after the CHK byte is accepted.
- Length error: error rises in the cycle after LEN_LO is accepted.
- start and a byte in the same cycle while in IDLE: only start takes effect, because rx_ready=0 there.
- wr_addr width arithmetic: after the final write with N = 2^ADDR_WIDTH, wr_addr wraps to 0. This is harmless, since the loader is already in CHECK.

## Test plan
- **Good load:** start, then bytes 00 02 20 08 00 05 8C 09 00 04 AE at one per cycle.
  - wr_en at addr 0 with data 0x20080005, then at addr 1 with data 0x8C090004, 4 cycles apart.
  - done=1, cpu_reset=0, error=0.
- **Bad checksum:** same frame with CHK=AF.
  - Both writes still occur.
  - error=1, cpu_reset stays 1, done=0.
  - A following start with the correct frame ends in done=1.
- **Zero length:** start, then 00 00 00.
  - No wr_en.
  - done=1 two cycles after the LEN_LO edge.
- **Oversize:** start, then 10 01 (N=4097, ADDR_WIDTH=12).
  - error=1 next cycle, rx_ready=0, no writes.
  - N=0x1000 is accepted.
- **Backpressure gaps:** the good-load frame with rx_valid low for 3 random cycles between bytes.
  - Identical writes and final done=1.
  - No extra wr_en during the gaps.
- **Reset mid-load:** assert reset asynchronously after 6 data bytes.
  - Outputs return to reset values without a clock edge.
  - No further writes.
  - A new start with the full frame loads addr 0 from the beginning.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed, checksummed byte stream
// and writes big-endian 32-bit words, holding the CPU in reset until a good load.
module imem_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t      state, state_nx;
    logic        accept;
    logic [7:0]  len_hi;
    logic [15:0] len_n;
    logic [15:0] words_left;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  chk;

    always_comb begin
        rx_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
        accept    = rx_valid && rx_ready;
        len_n     = {len_hi, rx_data};
        done      = (state == S_DONE);
        error     = (state == S_ERROR);
        cpu_reset = (state != S_DONE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) state_nx = S_LEN_HI;
            S_LEN_HI:
                if (accept) state_nx = S_LEN_LO;
            S_LEN_LO:
                if (accept) begin
                    if (len_n == '0)
                        state_nx = S_CHECK;
                    else if ({1'b0, len_n} > CAPACITY)
                        state_nx = S_ERROR;
                    else
                        state_nx = S_DATA;
                end
            S_DATA:
                if (accept && byte_cnt == 2'd3 && words_left == 16'd1)
                    state_nx = S_CHECK;
            S_CHECK:
                if (accept) state_nx = (rx_data == chk) ? S_DONE : S_ERROR;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            chk        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            // Address advances on the edge that ends each write strobe.
            if (wr_en)
                wr_addr <= wr_addr + 1'b1;
            case (state)
                S_IDLE, S_DONE, S_ERROR:
                    if (start) begin
                        wr_addr  <= '0;
                        chk      <= '0;
                        byte_cnt <= '0;
                    end
                S_LEN_HI:
                    if (accept) begin
                        len_hi <= rx_data;
                        chk    <= chk ^ rx_data;
                    end
                S_LEN_LO:
                    if (accept) begin
                        words_left <= len_n;
                        chk        <= chk ^ rx_data;
                    end
                S_DATA:
                    if (accept) begin
                        chk      <= chk ^ rx_data;
                        shift    <= {shift[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_data    <= {shift, rx_data};
                            wr_en      <= 1'b1;
                            words_left <= words_left - 16'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frame loads, checksum and length
// errors, backpressure, full-capacity wrap and asynchronous reset mid-load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] frame[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (!reset && wr_en) wq.push_back('{wr_addr, wr_data, cyc});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            check("accept_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (max_gap > 0 && i < frame.size() - 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'hFF;
                repeat ($urandom_range(1, max_gap)) @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_good_frame();
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                  8'h8C, 8'h09, 8'h00, 8'h04, 8'hAE};
    endtask

    task automatic check_good_writes(input string pfx);
        check({pfx, "_nwr"}, 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check({pfx, "_a0"}, 32'(wq[0].addr), 32'd0);
            check({pfx, "_d0"}, wq[0].data, 32'h20080005);
            check({pfx, "_a1"}, 32'(wq[1].addr), 32'd1);
            check({pfx, "_d1"}, wq[1].data, 32'h8C090004);
        end
    endtask

    initial begin
        logic [7:0]  x;
        logic [31:0] w;
        int          bad;

        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Good load, one byte per cycle, with strobe timing checked in-line
        set_good_frame();
        wq.delete();
        do_start();
        check("good_rx_ready", 32'(rx_ready), 32'd1);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i == 5) begin
                check("good_wr_en0", 32'(wr_en), 32'd1);
                check("good_wr_addr0", 32'(wr_addr), 32'd0);
                check("good_wr_data0", wr_data, 32'h20080005);
            end
            if (i == 6) begin
                check("good_wr_en_off", 32'(wr_en), 32'd0);
                check("good_addr_adv", 32'(wr_addr), 32'd1);
            end
        end
        rx_valid = 1'b0;
        check_good_writes("good");
        if (wq.size() == 2) check("good_spacing", 32'(wq[1].cyc - wq[0].cyc), 32'd4);
        check("good_done", 32'(done), 32'd1);
        check("good_cpu_reset", 32'(cpu_reset), 32'd0);
        check("good_error", 32'(error), 32'd0);
        check("good_rx_ready_end", 32'(rx_ready), 32'd0);

        // Bad checksum, then a correct retry
        set_good_frame();
        frame[10] = 8'hAF;
        wq.delete();
        do_start();
        check("bad_cpu_reset_start", 32'(cpu_reset), 32'd1);
        send_frame(0);
        check_good_writes("bad");
        check("bad_error", 32'(error), 32'd1);
        check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        set_good_frame();
        wq.delete();
        do_start();
        check("retry_error_clr", 32'(error), 32'd0);
        send_frame(0);
        check_good_writes("retry");
        check("retry_done", 32'(done), 32'd1);

        // Zero length
        frame = '{8'h00, 8'h00, 8'h00};
        wq.delete();
        do_start();
        send_frame(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        check("zero_nwr", 32'(wq.size()), 32'd0);

        // Oversize length (4097 words)
        frame = '{8'h10, 8'h01};
        wq.delete();
        do_start();
        send_frame(0);
        check("over_error", 32'(error), 32'd1);
        check("over_rx_ready", 32'(rx_ready), 32'd0);
        check("over_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("over_nwr", 32'(wq.size()), 32'd0);

        // Full capacity (4096 words): accepted, and wr_addr wraps to 0 afterwards
        frame = '{8'h10, 8'h00};
        x = 8'h10;
        for (int k = 0; k < 4096; k++) begin
            w = {8'(k) ^ 8'h5A, 8'hC3, 4'h0, 12'(k)};
            for (int b = 3; b >= 0; b--) begin
                frame.push_back(w[b*8 +: 8]);
                x ^= w[b*8 +: 8];
            end
        end
        frame.push_back(x);
        wq.delete();
        do_start();
        send_byte(frame[0]);
        send_byte(frame[1]);
        check("full_accept_rx_ready", 32'(rx_ready), 32'd1);
        check("full_accept_error", 32'(error), 32'd0);
        frame = frame[2:$];
        send_frame(0);
        check("full_nwr", 32'(wq.size()), 32'd4096);
        bad = 0;
        for (int k = 0; k < wq.size(); k++)
            if (wq[k].addr !== 12'(k) || wq[k].data !== {8'(k) ^ 8'h5A, 8'hC3, 4'h0, 12'(k)})
                bad++;
        check("full_contents_bad", 32'(bad), 32'd0);
        check("full_addr_wrap", 32'(wr_addr), 32'd0);
        check("full_done", 32'(done), 32'd1);

        // Backpressure gaps
        set_good_frame();
        wq.delete();
        do_start();
        send_frame(3);
        check_good_writes("gap");
        check("gap_done", 32'(done), 32'd1);

        // Asynchronous reset after 6 data bytes
        set_good_frame();
        wq.delete();
        do_start();
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        rx_valid = 1'b0;
        check("mid_addr_pre", 32'(wr_addr), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rx_ready", 32'(rx_ready), 32'd0);
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_wr_data", wr_data, 32'd0);
        check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_nwr", 32'(wq.size()), 32'd1);
        wq.delete();
        do_start();
        send_frame(0);
        check_good_writes("reload");
        check("reload_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
